// File: rtl/als_spi_responder.sv
// als_spi_responder: SPI responder that serves an 8-bit light value MSB first
// and captures the master's MOSI bits, reporting good and bad frames.
// SCLK, CS and MOSI are asynchronous to Clock and are synchronised here.
// Optional feature: define ALS_RESP_FRAME_COUNT_EN to add the 8-bit
// frameCount output, which counts good frames modulo 256.
module als_spi_responder #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            illumValue,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [FRAME_BITS-1:0] rxData,
  output logic                  frameDone,
  output logic                  frameErr
`ifdef ALS_RESP_FRAME_COUNT_EN
  ,
  output logic [7:0]            frameCount
`endif
);

  localparam int unsigned CNT_MAX = 2 * FRAME_BITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FILL_W  = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_hist;
  logic                   cs_hist;
  logic                   mosi_hist;
  logic [FILL_W-1:0]      fill_cnt;

  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  rxsh;
  logic [CNT_W-1:0]       edge_cnt;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_fall_c;
  logic                   sclk_rise_c;
  logic                   cs_fall_c;
  logic                   cs_rise_c;
  logic                   sync_primed_c;
  logic [15:0]            load16_c;
  logic [FRAME_BITS-1:0]  load_val_c;

  logic                   load_c;
  logic                   do_shift_c;
  logic                   do_rx_c;
  logic                   close_ok_c;
  logic                   close_err_c;

  // Synchroniser chains plus one history flop per input for edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b1;
      cs_hist   <= 1'b1;
      mosi_hist <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
      mosi_hist <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Count cycles since reset until the chains hold real pin values, so the
  // reset-preset CS=1 cannot be mistaken for a released chip select.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fill_cnt <= '0;
    end else if (!sync_primed_c) begin
      fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  // Edge detection on synchronised values only.
  always_comb begin
    sclk_s        = sclk_sync[SYNC_STAGES-1];
    cs_s          = cs_sync[SYNC_STAGES-1];
    sclk_fall_c   = sclk_hist & ~sclk_s;
    sclk_rise_c   = ~sclk_hist & sclk_s;
    cs_fall_c     = cs_hist & ~cs_s;
    cs_rise_c     = ~cs_hist & cs_s;
    sync_primed_c = (fill_cnt == FILL_W'(SYNC_STAGES + 1));
    load16_c      = {4'b0000, illumValue, 4'b0000};
    load_val_c    = FRAME_BITS'(load16_c);
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (sync_primed_c && cs_s) state_d = IDLE;
      IDLE:      if (cs_fall_c)             state_d = SHIFT;
      SHIFT:     if (cs_rise_c)             state_d = IDLE;
      default:                              state_d = WAIT_IDLE;
    endcase
  end

  // FSM output decode; a CS release takes priority over any SCLK edge.
  always_comb begin
    load_c      = 1'b0;
    do_shift_c  = 1'b0;
    do_rx_c     = 1'b0;
    close_ok_c  = 1'b0;
    close_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        load_c = cs_fall_c;
      end
      SHIFT: begin
        if (cs_rise_c) begin
          close_ok_c  = (edge_cnt == CNT_W'(FRAME_BITS));
          close_err_c = (edge_cnt != CNT_W'(FRAME_BITS));
        end else begin
          do_shift_c = sclk_fall_c;
          do_rx_c    = sclk_rise_c;
        end
      end
      default: ;
    endcase
  end

  // Transmit shift register and saturating falling-edge counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg    <= '0;
      edge_cnt <= '0;
    end else if (load_c) begin
      shreg    <= load_val_c;
      edge_cnt <= '0;
    end else if (do_shift_c) begin
      shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
      if (edge_cnt != CNT_W'(CNT_MAX)) begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

  // Receive shift register, cleared at frame start, sampled on SCLK rise.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rxsh <= '0;
    end else if (load_c) begin
      rxsh <= '0;
    end else if (do_rx_c) begin
      rxsh <= {rxsh[FRAME_BITS-2:0], mosi_hist};
    end
  end

  // Registered outputs: MISO follows the shift MSB only while in SHIFT.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      MISO      <= 1'b0;
      rxData    <= '0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      MISO      <= (state_q == SHIFT) ? shreg[FRAME_BITS-1] : 1'b0;
      frameDone <= close_ok_c;
      frameErr  <= close_err_c;
      if (close_ok_c) begin
        rxData <= rxsh;
      end
    end
  end

`ifdef ALS_RESP_FRAME_COUNT_EN
  // Good-frame counter, wraps at 256; error frames leave it alone.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      frameCount <= 8'd0;
    end else if (close_ok_c) begin
      frameCount <= frameCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_als_spi_responder.sv
// Scoreboard bench for als_spi_responder: stimulus tasks push expected frame
// results and MISO bits; independent monitors pop and compare them.
module tb_als_spi_responder;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [15:0] rx;
  } res_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  illumValue;
  logic        SCLK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic [15:0] rxData;
  logic        frameDone;
  logic        frameErr;
`ifdef ALS_RESP_FRAME_COUNT_EN
  logic [7:0]  frameCount;
  int          exp_fc = 0;
`endif

  res_t        res_q[$];
  bit          miso_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hp = 8;
  logic [15:0] last_good = 16'h0000;

  als_spi_responder #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .illumValue (illumValue),
    .SCLK       (SCLK),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .rxData     (rxData),
    .frameDone  (frameDone),
    .frameErr   (frameErr)
`ifdef ALS_RESP_FRAME_COUNT_EN
    ,
    .frameCount (frameCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Frame-result monitor.
  initial begin
    res_t e;
    forever begin
      @(negedge Clock);
      if (frameDone && frameErr) begin
        n_cmp++; n_bad++;
        $display("FAIL both_pulses: frameDone=1 frameErr=1, required at most one");
      end
      if (frameDone || frameErr) begin
        n_cmp++;
        if (res_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b, required no pulse", frameDone, frameErr);
        end else begin
          e = res_q.pop_front();
          if (frameDone !== e.done || frameErr !== e.err || rxData !== e.rx) begin
            n_bad++;
            $display("FAIL frame_result: done=%0b err=%0b rx=%h, required done=%0b err=%0b rx=%h",
                     frameDone, frameErr, rxData, e.done, e.err, e.rx);
          end
        end
      end
    end
  end

  // MISO monitor: sampled at each SCLK pin fall, before that fall's shift.
  initial begin
    bit eb;
    forever begin
      @(negedge SCLK);
      n_cmp++;
      if (miso_q.size() == 0) begin
        n_bad++;
        $display("FAIL miso_unexpected_edge: MISO=%0b, required no SCLK edge", MISO);
      end else begin
        eb = miso_q.pop_front();
        if (MISO !== eb) begin
          n_bad++;
          $display("FAIL miso_bit: MISO=%0b, required %0b", MISO, eb);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 40 && res_q.size() != 0; i++) @(negedge Clock);
    if (res_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", res_q.size());
      res_q.delete();
    end
`ifdef ALS_RESP_FRAME_COUNT_EN
    n_cmp++;
    if (frameCount !== 8'(exp_fc)) begin
      n_bad++;
      $display("FAIL frame_count: got %0d, required %0d", frameCount, 8'(exp_fc));
    end
`endif
  endtask

  // One SPI frame; cs_last releases CS together with the final falling edge,
  // rst_at pulses Reset after that many falls (no result expected then).
  task automatic frame(input logic [7:0] illum, input logic [15:0] mosi,
                       input int nfalls, input int chg_at, input logic [7:0] chg_val,
                       input bit cs_last, input int rst_at);
    logic [15:0] sh;
    int          cnt;
    res_t        r;
    sh  = {4'b0000, illum, 4'b0000};
    cnt = cs_last ? nfalls - 1 : nfalls;
    if (rst_at == 0) begin
      r.done = (cnt == 16);
      r.err  = (cnt != 16);
      r.rx   = r.done ? mosi : last_good;
      res_q.push_back(r);
      if (r.done) begin
        last_good = mosi;
`ifdef ALS_RESP_FRAME_COUNT_EN
        exp_fc = (exp_fc + 1) % 256;
`endif
      end
    end
    @(negedge Clock);
    illumValue = illum;
    CS = 1'b0;
    repeat (hp) @(negedge Clock);
    for (int k = 1; k <= nfalls; k++) begin
      miso_q.push_back(sh[15]);
      sh = {sh[14:0], 1'b0};
      if (cs_last && k == nfalls) begin
        SCLK = 1'b0;
        CS = 1'b1;
      end else begin
        SCLK = 1'b0;
        MOSI = (k <= 16) ? mosi[16-k] : 1'b0;
      end
      if (k == chg_at) illumValue = chg_val;
      repeat (hp) @(negedge Clock);
      if (!(cs_last && k == nfalls)) begin
        SCLK = 1'b1;
        repeat (hp) @(negedge Clock);
      end
      if (k == rst_at) begin
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        sh = 16'h0000;
`ifdef ALS_RESP_FRAME_COUNT_EN
        exp_fc = 0;
`endif
      end
    end
    if (!cs_last) CS = 1'b1;
    repeat (hp) @(negedge Clock);
    if (cs_last) SCLK = 1'b1;
    wait_drain();
    repeat (hp) @(negedge Clock);
  endtask

  task automatic check0(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    Reset = 1'b1;
    illumValue = 8'h00;
    SCLK = 1'b1;
    CS = 1'b1;
    MOSI = 1'b0;
    repeat (4) @(negedge Clock);
    check0("reset_miso", 32'(MISO), 32'h0);
    check0("reset_rxdata", 32'(rxData), 32'h0);
    check0("reset_done", 32'(frameDone), 32'h0);
    check0("reset_err", 32'(frameErr), 32'h0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    // Basic good frame: MISO 0000_1010_0101_0000, rxData 1234.
    frame(8'hA5, 16'h1234, 16, 0, 8'h00, 1'b0, 0);
    // illumValue changes after fall 4: frame still serves 3C.
    frame(8'h3C, 16'hBEEF, 16, 4, 8'hFF, 1'b0, 0);
    // Short frame: error, rxData holds BEEF.
    frame(8'h81, 16'hFFFF, 9, 0, 8'h00, 1'b0, 0);
    // Long frame: error, MISO 0 after fall 16.
    frame(8'hFF, 16'h5555, 20, 0, 8'h00, 1'b0, 0);
    // Reset after fall 7 with CS still low: no pulse, MISO stays 0.
    frame(8'hA5, 16'h0F0F, 10, 0, 8'h00, 1'b0, 7);
    check0("post_reset_rxdata", 32'(rxData), 32'h0);
    last_good = 16'h0000;
    // Recovery frame after reset.
    frame(8'h5A, 16'hC3A5, 16, 0, 8'h00, 1'b0, 0);
    // CS rises with the 16th fall: count 15, error.
    frame(8'h77, 16'hAAAA, 16, 0, 8'h00, 1'b1, 0);
    // Good frame after the collision case.
    frame(8'h01, 16'h8001, 16, 0, 8'h00, 1'b0, 0);

`ifdef ALS_RESP_FRAME_COUNT_EN
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    exp_fc = 0;
    last_good = 16'h0000;
    repeat (10) @(negedge Clock);
    hp = 5;
    for (int f = 0; f < 257; f++) frame(8'(f), 16'(f * 3), 16, 0, 8'h00, 1'b0, 0);
    frame(8'h11, 16'h2222, 5, 0, 8'h00, 1'b0, 0);
    check0("frame_count_257_plus_bad", 32'(frameCount), 32'd1);
`endif

    check0("miso_queue_empty", 32'(miso_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
